// File: rtl/demux_1_4_tdm.sv
// TDM 1:4 demultiplexer: steers a rotating serial sample stream into four lanes.
// Ports: clk_in, rst_in, d_in, valid_in, sync_in -> y_out, strb_out, sel_out,
//        frame_out, err_out, lock_out (all outputs registered).
module demux_1_4_tdm #(
  parameter int WIDTH = 8
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic [WIDTH-1:0]   d_in,
  input  logic               valid_in,
  input  logic               sync_in,
  output logic [4*WIDTH-1:0] y_out,
  output logic [3:0]         strb_out,
  output logic [1:0]         sel_out,
  output logic               frame_out,
  output logic               err_out,
  output logic               lock_out
);

  typedef enum logic {
    HUNT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         sel_q, sel_d;
  logic [4*WIDTH-1:0] y_q, y_d;
  logic [3:0]         strb_q, strb_d;
  logic               frame_q, frame_d;
  logic               err_q, err_d;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= HUNT;
      sel_q   <= 2'd0;
      y_q     <= '0;
      strb_q  <= 4'd0;
      frame_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      y_q     <= y_d;
      strb_q  <= strb_d;
      frame_q <= frame_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    y_d     = y_q;
    strb_d  = 4'd0;
    frame_d = 1'b0;
    err_d   = 1'b0;
    if (valid_in) begin
      unique case (state_q)
        HUNT: begin
          // Drop everything until the first channel-0 marker.
          if (sync_in) begin
            y_d[0 +: WIDTH] = d_in;
            strb_d  = 4'b0001;
            sel_d   = 2'd1;
            state_d = RUN;
          end
        end
        RUN: begin
          if (sync_in) begin
            // Sync always realigns to lane 0; off-slot sync aborts the frame.
            y_d[0 +: WIDTH] = d_in;
            strb_d = 4'b0001;
            sel_d  = 2'd1;
            err_d  = (sel_q != 2'd0);
          end else begin
            for (int k = 0; k < 4; k++) begin
              if (sel_q == 2'(k)) y_d[k*WIDTH +: WIDTH] = d_in;
            end
            strb_d  = 4'b0001 << sel_q;
            sel_d   = sel_q + 2'd1;
            frame_d = (sel_q == 2'd3);
          end
        end
      endcase
    end
  end

  assign y_out     = y_q;
  assign strb_out  = strb_q;
  assign sel_out   = sel_q;
  assign frame_out = frame_q;
  assign err_out   = err_q;
  assign lock_out  = (state_q == RUN);

endmodule

// File: tb/tb_demux_1_4_tdm.sv
// Directed bench for demux_1_4_tdm.
// Drives a linear stimulus sequence and checks outputs 1 time unit after edges.
module tb_demux_1_4_tdm;

  logic        clk;
  logic        rst;
  logic [7:0]  d;
  logic        valid;
  logic        sync;
  logic [31:0] y;
  logic [3:0]  strb;
  logic [1:0]  sel;
  logic        frame;
  logic        err;
  logic        lock;

  int errors = 0;
  int checks = 0;

  demux_1_4_tdm #(.WIDTH(8)) dut (
    .clk_in    (clk),
    .rst_in    (rst),
    .d_in      (d),
    .valid_in  (valid),
    .sync_in   (sync),
    .y_out     (y),
    .strb_out  (strb),
    .sel_out   (sel),
    .frame_out (frame),
    .err_out   (err),
    .lock_out  (lock)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic s, input logic [7:0] dv);
    valid = v;
    sync  = s;
    d     = dv;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; sync = 1'b0; d = 8'h00;

    // 1 reset with toggling inputs
    step(1'b1, 1'b1, 8'h77);
    step(1'b0, 1'b1, 8'h78);
    chk("rst_y",     y,            32'h0);
    chk("rst_strb",  {28'd0, strb}, 32'h0);
    chk("rst_sel",   {30'd0, sel},  32'h0);
    chk("rst_frame", {31'd0, frame}, 32'h0);
    chk("rst_err",   {31'd0, err},   32'h0);
    chk("rst_lock",  {31'd0, lock},  32'h0);
    rst = 1'b0;

    // 2 hunt
    step(1'b1, 1'b0, 8'h11);
    chk("hunt1_strb", {28'd0, strb}, 32'h0);
    chk("hunt1_lock", {31'd0, lock}, 32'h0);
    step(1'b1, 1'b0, 8'h22);
    chk("hunt2_strb", {28'd0, strb}, 32'h0);
    chk("hunt2_y",    y,             32'h0);
    step(1'b1, 1'b1, 8'hA0);
    chk("sync_y",    y,             32'h0000_00A0);
    chk("sync_strb", {28'd0, strb}, 32'h1);
    chk("sync_sel",  {30'd0, sel},  32'h1);
    chk("sync_lock", {31'd0, lock}, 32'h1);

    // 3 frame with gaps
    idle(2);
    chk("gap_strb", {28'd0, strb}, 32'h0);
    step(1'b1, 1'b0, 8'hA1);
    chk("a1_strb",  {28'd0, strb},  32'h2);
    chk("a1_frame", {31'd0, frame}, 32'h0);
    chk("a1_sel",   {30'd0, sel},   32'h2);
    idle(1);
    step(1'b1, 1'b0, 8'hA2);
    chk("a2_strb",  {28'd0, strb},  32'h4);
    chk("a2_frame", {31'd0, frame}, 32'h0);
    idle(3);
    step(1'b1, 1'b0, 8'hA3);
    chk("a3_strb",  {28'd0, strb},  32'h8);
    chk("a3_frame", {31'd0, frame}, 32'h1);
    chk("a3_y",     y,              32'hA3A2_A1A0);
    chk("a3_sel",   {30'd0, sel},   32'h0);
    idle(1);
    chk("a3_frame_low", {31'd0, frame}, 32'h0);
    chk("a3_strb_low",  {28'd0, strb},  32'h0);

    // sync without valid is ignored
    step(1'b0, 1'b1, 8'h99);
    chk("nv_sync_err", {31'd0, err},  32'h0);
    chk("nv_sync_sel", {30'd0, sel},  32'h0);
    chk("nv_sync_y",   y,             32'hA3A2_A1A0);

    // 4 free-run frame
    step(1'b1, 1'b0, 8'hB0);
    chk("b0_strb", {28'd0, strb}, 32'h1);
    chk("b0_err",  {31'd0, err},  32'h0);
    step(1'b1, 1'b0, 8'hB1);
    step(1'b1, 1'b0, 8'hB2);
    chk("b2_frame", {31'd0, frame}, 32'h0);
    step(1'b1, 1'b0, 8'hB3);
    chk("b3_frame", {31'd0, frame}, 32'h1);
    chk("b3_y",     y,              32'hB3B2_B1B0);

    // 5 misalignment at sel=2
    step(1'b1, 1'b0, 8'hD0);
    step(1'b1, 1'b0, 8'hD1);
    chk("d1_sel", {30'd0, sel}, 32'h2);
    step(1'b1, 1'b1, 8'hC0);
    chk("mis_err",   {31'd0, err},   32'h1);
    chk("mis_strb",  {28'd0, strb},  32'h1);
    chk("mis_sel",   {30'd0, sel},   32'h1);
    chk("mis_frame", {31'd0, frame}, 32'h0);
    chk("mis_y",     y,              32'hB3B2_D1C0);
    chk("mis_lock",  {31'd0, lock},  32'h1);
    step(1'b1, 1'b0, 8'hE1);
    chk("e1_err",  {31'd0, err},  32'h0);
    chk("e1_strb", {28'd0, strb}, 32'h2);
    chk("e1_y",    y,             32'hB3B2_E1C0);
    step(1'b1, 1'b0, 8'hE2);
    step(1'b1, 1'b0, 8'hE3);
    chk("e3_frame", {31'd0, frame}, 32'h1);
    chk("e3_y",     y,              32'hE3E2_E1C0);

    // 6 reset mid-frame
    step(1'b1, 1'b1, 8'hF0);
    chk("f0_err", {31'd0, err}, 32'h0);
    step(1'b1, 1'b0, 8'hF1);
    chk("f1_y", y, 32'hE3E2_F1F0);
    rst = 1'b1;
    step(1'b1, 1'b0, 8'hF2);
    rst = 1'b0;
    chk("mrst_y",    y,             32'h0);
    chk("mrst_lock", {31'd0, lock}, 32'h0);
    chk("mrst_sel",  {30'd0, sel},  32'h0);
    chk("mrst_strb", {28'd0, strb}, 32'h0);
    step(1'b1, 1'b0, 8'h55);
    chk("post_strb", {28'd0, strb}, 32'h0);
    chk("post_y",    y,             32'h0);
    chk("post_lock", {31'd0, lock}, 32'h0);
    step(1'b1, 1'b1, 8'h66);
    chk("relock_y",    y,             32'h0000_0066);
    chk("relock_lock", {31'd0, lock}, 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
